// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked parametrised ALU with shifts, set-less-than and an
//                optional iterative shift-add multiplier (macro ALU_SEQ_MUL_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam logic [3:0] C_OP_ADD  = 4'd0;
   localparam logic [3:0] C_OP_AND  = 4'd1;
   localparam logic [3:0] C_OP_OR   = 4'd2;
   localparam logic [3:0] C_OP_SUB  = 4'd3;
   localparam logic [3:0] C_OP_XOR  = 4'd4;
   localparam logic [3:0] C_OP_SLT  = 4'd5;
   localparam logic [3:0] C_OP_NOR  = 4'd6;
   localparam logic [3:0] C_OP_SLL  = 4'd7;
   localparam logic [3:0] C_OP_SRL  = 4'd8;
   localparam logic [3:0] C_OP_SRA  = 4'd9;
   localparam logic [3:0] C_OP_SLTU = 4'd11;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_carry;
   logic             r_overflow;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_sll;
   logic [WIDTH:0]   w_srl;
   logic [WIDTH:0]   w_sra;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_legal;
   logic             w_accept;

   logic             w_ld;
   logic [WIDTH-1:0] w_ld_res;
   logic             w_ld_zero;
   logic             w_ld_c;
   logic             w_ld_v;

   // Shift operands carry one extra bit so the last bit shifted out lands there.
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_sll  = {1'b0, a} << shamt;
   assign w_srl  = {a, 1'b0} >> shamt;
   assign w_sra  = $signed({a, 1'b0}) >>> shamt;

   always_comb begin
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      w_legal = 1'b1;
      case (op)
         C_OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         C_OP_AND:  w_res = a & b;
         C_OP_OR:   w_res = a | b;
         C_OP_SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         C_OP_XOR:  w_res = a ^ b;
         C_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         C_OP_NOR:  w_res = ~(a | b);
         C_OP_SLL: begin
            w_res = w_sll[WIDTH-1:0];
            w_c   = w_sll[WIDTH];
         end
         C_OP_SRL: begin
            w_res = w_srl[WIDTH:1];
            w_c   = w_srl[0];
         end
         C_OP_SRA: begin
            w_res = w_sra[WIDTH:1];
            w_c   = w_sra[0];
         end
         C_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default:   w_legal = 1'b0;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0]     C_OP_MUL = 4'd10;
   localparam logic [SHW-1:0] C_LAST   = SHW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MULT = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_busy;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [SHW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_fin;
   logic               w_is_mul;

   assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_is_mul   = (op == C_OP_MUL);
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_fin      = (r_state == S_MULT) && (r_cnt == C_LAST);

   // The final iteration's sum goes straight into the output register.
   assign w_ld      = (w_accept && !w_is_mul) || w_fin;
   assign w_ld_res  = w_fin ? w_acc_next[WIDTH-1:0] : w_res;
   assign w_ld_c    = w_fin ? (|w_acc_next[2*WIDTH-1:WIDTH]) : w_c;
   assign w_ld_v    = w_fin ? (|w_acc_next[2*WIDTH-1:WIDTH]) : w_v;
   assign w_ld_zero = w_fin ? (w_acc_next[WIDTH-1:0] == '0) : (w_legal && (w_res == '0));
   assign busy      = r_busy;
`else
   assign in_ready  = !r_out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   assign w_ld      = w_accept;
   assign w_ld_res  = w_res;
   assign w_ld_c    = w_c;
   assign w_ld_v    = w_v;
   assign w_ld_zero = w_legal && (w_res == '0);
   assign busy      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
`endif
      end else begin
`ifdef ALU_SEQ_MUL_EN
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_state  <= S_MULT;
                  r_busy   <= 1'b1;
                  r_mcand  <= {{WIDTH{1'b0}}, a};
                  r_mplier <= b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_MULT: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_fin) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
`endif
         if (w_ld) begin
            r_out_valid <= 1'b1;
            r_result    <= w_ld_res;
            r_zero      <= w_ld_zero;
            r_carry     <= w_ld_c;
            r_overflow  <= w_ld_v;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign carry     = r_carry;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH = 8): directed table,
//                multi-cycle corner sequences and randomized scoreboard run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [3:0]    op = '0;
   logic [SW-1:0] shamt = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          zero;
   logic          carry;
   logic          overflow;
   logic          busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry),
      .overflow(overflow), .busy(busy)
   );

   typedef struct {
      logic [3:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [SW-1:0] sh;
      logic [W-1:0]  res;
      logic          z;
      logic          c;
      logic          v;
   } vec_t;

   vec_t tv[13];
   logic [10:0] sb_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: {overflow, carry, zero, result[7:0]} from plain integer math.
   function automatic logic [10:0] ref_op(input int o, input int x, input int y, input int s);
      int sx, sy, r, c, v, z, legal;
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      r = 0; c = 0; v = 0; legal = 1;
      case (o)
         0: begin r = x + y; c = (r > 255) ? 1 : 0; v = ((sx + sy > 127) || (sx + sy < -128)) ? 1 : 0; end
         1: r = x & y;
         2: r = x | y;
         3: begin r = x - y; c = (x < y) ? 1 : 0; v = ((sx - sy > 127) || (sx - sy < -128)) ? 1 : 0; end
         4: r = x ^ y;
         5: r = (sx < sy) ? 1 : 0;
         6: r = ~(x | y);
         7: begin r = x * (1 << s); c = (s > 0) ? ((x >> (8 - s)) & 1) : 0; end
         8: begin r = x / (1 << s); c = (s > 0) ? ((x >> (s - 1)) & 1) : 0; end
         9: begin r = sx >>> s;    c = (s > 0) ? ((x >> (s - 1)) & 1) : 0; end
`ifdef ALU_SEQ_MUL_EN
         10: begin r = x * y; c = (r > 255) ? 1 : 0; v = c; end
`endif
         11: r = (x < y) ? 1 : 0;
         default: legal = 0;
      endcase
      r = r & 255;
      z = (legal != 0 && r == 0) ? 1 : 0;
      return {v[0], c[0], z[0], r[7:0]};
   endfunction

   task automatic present(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
      in_valid = 1'b1;
      op = o; a = x; b = y; shamt = s;
   endtask

   initial begin
      tv[0]  = '{4'd0,  8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1};
      tv[1]  = '{4'd3,  8'h00, 8'h01, 3'd0, 8'hFF, 1'b0, 1'b1, 1'b0};
      tv[2]  = '{4'd9,  8'h80, 8'h00, 3'd3, 8'hF0, 1'b0, 1'b0, 1'b0};
      tv[3]  = '{4'd7,  8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 1'b1, 1'b0};
      tv[4]  = '{4'd1,  8'hF0, 8'h0F, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[5]  = '{4'd5,  8'h80, 8'h01, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0};
      tv[6]  = '{4'd11, 8'h80, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
      tv[7]  = '{4'd6,  8'h00, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{4'd8,  8'h05, 8'h00, 3'd1, 8'h02, 1'b0, 1'b1, 1'b0};
      tv[9]  = '{4'd0,  8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
      tv[10] = '{4'd3,  8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1};
      tv[11] = '{4'd14, 8'hA5, 8'h5A, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
      tv[12] = '{4'd7,  8'h81, 8'h00, 3'd0, 8'h81, 1'b0, 1'b0, 1'b0};

      // Reset state
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {zero, carry, overflow, busy}, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 1);

      // Directed table, one op per cycle with out_ready high
      for (int i = 0; i < 13; i++) begin
         present(tv[i].op, tv[i].a, tv[i].b, tv[i].sh);
         tick();
         in_valid = 1'b0;
         chk($sformatf("tv%0d_valid", i), out_valid, 1);
         chk($sformatf("tv%0d_result", i), result, tv[i].res);
         chk($sformatf("tv%0d_flags", i), {zero, carry, overflow}, {tv[i].z, tv[i].c, tv[i].v});
      end
      tick();
      chk("drain_valid", out_valid, 0);

      // Multiply timing
      present(4'd10, 8'h10, 8'h10, 3'd0);
      tick();
      in_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      for (int k = 1; k <= W; k++) begin
         chk($sformatf("mul_busy_c%0d", k), {busy, in_ready, out_valid}, 3'b100);
         tick();
      end
      chk("mul_done_valid", {out_valid, busy}, 2'b10);
      chk("mul_result", result, 8'h00);
      chk("mul_flags", {zero, carry, overflow}, 3'b111);
`else
      chk("mul_off_valid", {out_valid, busy}, 2'b10);
      chk("mul_off_result", result, 8'h00);
      chk("mul_off_flags", {zero, carry, overflow}, 3'b000);
`endif
      tick();

      // Backpressure: result holds, next op waits, then enters on release cycle
      out_ready = 1'b0;
      present(4'd0, 8'h01, 8'h02, 3'd0);
      tick();
      present(4'd4, 8'h0F, 8'hFF, 3'd0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_hold_c%0d", k), {out_valid, in_ready, result}, {1'b1, 1'b0, 8'h03});
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("bp_next_op", {out_valid, result}, {1'b1, 8'hF0});
      tick();
      chk("bp_drained", out_valid, 0);

      // Reset while work is in flight
`ifdef ALU_SEQ_MUL_EN
      present(4'd10, 8'hFF, 8'hFF, 3'd0);
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("midmul_busy", busy, 1);
`else
      out_ready = 1'b0;
      present(4'd0, 8'h01, 8'h02, 3'd0);
      tick();
      in_valid = 1'b0;
      chk("prerst_valid", out_valid, 1);
`endif
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {out_valid, busy, zero, carry, overflow, result}, 0);
      tick();
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("abort_in_ready", in_ready, 1);
      begin
         int pulses;
         pulses = 0;
         for (int k = 0; k < 12; k++) begin
            if (out_valid) pulses++;
            tick();
         end
         chk("abort_no_pulse", pulses, 0);
      end

      // Randomized run against the reference model
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         op        = 4'($urandom_range(0, 15));
         a         = 8'($urandom);
         b         = 8'($urandom);
         shamt     = 3'($urandom);
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("rnd_spurious", 1, 0);
            end else begin
               logic [10:0] e;
               e = sb_q.pop_front();
               chk($sformatf("rnd_c%0d", cyc), {overflow, carry, zero, result}, e);
            end
         end
         if (in_valid && in_ready) sb_q.push_back(ref_op(op, a, b, shamt));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3 * W; k++) begin
         @(negedge clk);
         if (out_valid && sb_q.size() != 0) begin
            logic [10:0] e;
            e = sb_q.pop_front();
            chk("rnd_drain", {overflow, carry, zero, result}, e);
         end
         tick();
      end
      chk("rnd_queue_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
